// File: rtl/serial_pkg.sv
// Shared definitions for the serial framer/deframer pair: FSM states, line levels, frame length.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam logic LVL_IDLE  = 1'b1;
  localparam logic LVL_START = 1'b0;
  localparam logic LVL_STOP  = 1'b1;

  // Clocks per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en);
    return data_w + parity_en + 2;
  endfunction

endpackage

// File: rtl/word_holding_reg.sv
// One-entry valid/ready word buffer; load registers in one cycle.
// Backpressure: a load while full and not being accepted is dropped and pulses overrun.
module word_holding_reg #(
  parameter int W = 8
) (
  input  logic         clkIn,
  input  logic         rstN,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_perr,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         perr,
  output logic         overrun
);

  logic can_load;

  // An accept in the same cycle frees the slot for the incoming word.
  assign can_load = !valid || ready;

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      data    <= '0;
      valid   <= 1'b0;
      perr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      if (load) begin
        if (can_load) begin
          data  <= load_data;
          perr  <= load_perr;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// Serial-to-parallel deframer: start, DATA_W bits LSB-first, optional even parity, stop.
// Latency DATA_W+2+PARITY_EN edges start-to-valid; full output buffer drops new words (overrun).
module serial_deframer
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clkIn,
  input  logic              rstN,
  input  logic              din,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              perr,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               perr_q, perr_d;
  logic               ferr_d;
  logic               load;

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      perr_q    <= perr_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (din == LVL_START) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      DATA: begin
        // New bits enter at the MSB so the first bit ends up in bit 0.
        shreg_d = {din, shreg_q[DATA_W-1:1]};
        par_d   = par_q ^ din;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        perr_d  = par_q ^ din;
        state_d = STOP;
      end
      STOP: begin
        if (din == LVL_STOP) begin
          load    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        // A line held low after a bad stop must not look like a fresh start bit.
        if (din == LVL_IDLE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  word_holding_reg #(
    .W (DATA_W)
  ) u_hold (
    .clkIn     (clkIn),
    .rstN      (rstN),
    .load      (load),
    .load_data (shreg_q),
    .load_perr (perr_q),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .perr      (perr),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: default 8-bit/parity instance plus a 5-bit no-parity instance.
module tb_serial_deframer;
  import serial_pkg::*;

  logic       clkIn = 1'b0;
  logic       rstN;
  logic       din, ready;
  logic [7:0] data;
  logic       valid, perr, frame_err, overrun;
  logic       din5, ready5;
  logic [4:0] data5;
  logic       valid5, perr5, frame_err5, overrun5;

  always #5 clkIn = ~clkIn;

  serial_deframer u_dut (
    .clkIn(clkIn), .rstN(rstN), .din(din), .ready(ready), .data(data),
    .valid(valid), .perr(perr), .frame_err(frame_err), .overrun(overrun)
  );

  serial_deframer #(.DATA_W(5), .PARITY_EN(0)) u_dut5 (
    .clkIn(clkIn), .rstN(rstN), .din(din5), .ready(ready5), .data(data5),
    .valid(valid5), .perr(perr5), .frame_err(frame_err5), .overrun(overrun5)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    logic       exp_perr;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame; returns right after the stop bit is driven (before its sampling edge).
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_b);
    @(negedge clkIn) din = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkIn) din = d[i];
    end
    @(negedge clkIn) din = (^d) ^ bad_par;
    @(negedge clkIn) din = stop_b;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clkIn);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still expected after %0d cycles", sb.size(), budget);
    end
  endtask

  // Scoreboard monitor: samples just after the falling edge, when inputs for the next edge are settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkIn);
      #1;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) begin
        errors++;
        $display("FAIL pulse_overlap: frame_err and overrun both high");
      end
      if (valid && ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data %0h perr %0b, expected none", data, perr);
        end else begin
          e = sb.pop_front();
          if (data !== e.d || perr !== e.perr) begin
            errors++;
            $display("FAIL word: got data %0h perr %0b expected data %0h perr %0b",
                     data, perr, e.d, e.perr);
          end
        end
      end
    end
  end

  initial begin
    vec_t       vecs[8];
    logic [6:0] f5;
    int         f0, o0;

    vecs[0] = '{d: 8'hA5, bad_par: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{d: 8'h01, bad_par: 1'b1, exp_perr: 1'b1};
    vecs[2] = '{d: 8'h55, bad_par: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{d: 8'hFF, bad_par: 1'b0, exp_perr: 1'b0};
    vecs[4] = '{d: 8'h00, bad_par: 1'b1, exp_perr: 1'b1};
    vecs[5] = '{d: 8'h3C, bad_par: 1'b1, exp_perr: 1'b1};
    vecs[6] = '{d: 8'hC3, bad_par: 1'b0, exp_perr: 1'b0};
    vecs[7] = '{d: 8'h80, bad_par: 1'b0, exp_perr: 1'b0};

    rstN = 1'b0; din = 1'b1; ready = 1'b1; din5 = 1'b1; ready5 = 1'b1;
    repeat (2) @(negedge clkIn);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_valid5", 32'(valid5), 32'h0);
    @(negedge clkIn) rstN = 1'b1;
    @(negedge clkIn);

    // 0xA5: valid must appear exactly after the stop edge and last one cycle.
    sb.push_back('{d: 8'hA5, perr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_no_early_valid", 32'(valid), 32'h0);
    @(negedge clkIn);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_perr", 32'(perr), 32'h0);
    @(negedge clkIn);
    chk("a5_valid_one_cycle", 32'(valid), 32'h0);

    sb.push_back('{d: 8'h01, perr: 1'b1});
    send_frame(8'h01, 1'b1, 1'b1);
    @(negedge clkIn);
    chk("perr_valid", 32'(valid), 32'h1);
    chk("perr_data", 32'(data), 32'h01);
    chk("perr_flag", 32'(perr), 32'h1);
    drain(20);

    // Back-to-back table frames at full throughput.
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{d: vecs[i].d, perr: vecs[i].exp_perr});
      send_frame(vecs[i].d, vecs[i].bad_par, 1'b1);
    end
    drain(20);

    // Bad stop bit, line held low, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    @(negedge clkIn) din = 1'b0;
    chk("ferr_pulse", 32'(frame_err), 32'h1);
    chk("ferr_no_valid", 32'(valid), 32'h0);
    repeat (4) @(negedge clkIn) din = 1'b0;
    @(negedge clkIn) din = 1'b1;
    sb.push_back('{d: 8'h55, perr: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1);
    drain(20);
    chk("ferr_single_pulse", 32'(ferr_cnt - f0), 32'h1);

    // Overrun with buffer full and no accept.
    ready = 1'b0;
    o0 = ovr_cnt;
    sb.push_back('{d: 8'h3C, perr: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    @(negedge clkIn);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_no_ferr", 32'(frame_err), 32'h0);
    chk("ovr_held_data", 32'(data), 32'h3C);
    chk("ovr_held_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    @(negedge clkIn);
    chk("ovr_single_pulse", 32'(ovr_cnt - o0), 32'h1);
    chk("ovr_valid_cleared", 32'(valid), 32'h0);
    drain(5);

    // Accept in the same cycle the next word completes.
    ready = 1'b0;
    o0 = ovr_cnt;
    sb.push_back('{d: 8'h3C, perr: 1'b0});
    sb.push_back('{d: 8'hC3, perr: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    ready = 1'b1;
    @(negedge clkIn);
    chk("swap_valid", 32'(valid), 32'h1);
    chk("swap_data", 32'(data), 32'hC3);
    chk("swap_no_overrun", 32'(overrun), 32'h0);
    @(negedge clkIn);
    chk("swap_valid_fall", 32'(valid), 32'h0);
    chk("swap_no_ovr_count", 32'(ovr_cnt - o0), 32'h0);
    drain(5);

    // Reset in the middle of a frame while a word is held.
    ready = 1'b0;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    @(negedge clkIn);
    chk("rst_mid_held", 32'(valid), 32'h1);
    @(negedge clkIn) din = 1'b0;
    @(negedge clkIn) din = 1'b1;
    @(negedge clkIn) din = 1'b0;
    @(negedge clkIn) din = 1'b0;
    @(negedge clkIn) din = 1'b0;
    @(negedge clkIn) rstN = 1'b0;
    #1;
    chk("rst_mid_data", 32'(data), 32'h0);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    chk("rst_mid_perr", 32'(perr), 32'h0);
    @(negedge clkIn) begin din = 1'b1; ready = 1'b1; end
    @(negedge clkIn) rstN = 1'b1;
    sb.push_back('{d: 8'h81, perr: 1'b0});
    send_frame(8'h81, 1'b0, 1'b1);
    drain(20);
    chk("rst_mid_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);

    // 5-bit, no parity: valid exactly frame_len edges after the start bit.
    f5 = 7'b1010110;
    for (int i = 0; i < int'(frame_len(5, 0)); i++) begin
      @(negedge clkIn) din5 = f5[i];
      chk("w5_no_early_valid", 32'(valid5), 32'h0);
    end
    @(negedge clkIn) din5 = 1'b1;
    chk("w5_valid", 32'(valid5), 32'h1);
    chk("w5_data", 32'(data5), 32'h0B);
    chk("w5_perr", 32'(perr5), 32'h0);
    chk("w5_no_ferr", 32'(frame_err5), 32'h0);

    repeat (3) @(negedge clkIn);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
